rvfi_shadow_pipe: RTL and testbench
===================================

Name: rvfi_shadow_pipe

Overview:
Parametrised RVFI monitor shadow pipeline. It captures per-instruction retirement metadata at the resolve point (EX), where the next PC is known, and carries it through STAGES shadow registers. Those registers follow the core's freeze, hold-with-bubble and flush rules. At the last stage it drives a complete RVFI commit packet, an order counter and a sticky halt flag. It instantiates once in the testbench top and replaces ad-hoc per-signal delay registers.

Parameters:
STAGES, 2, shadow stages from capture to commit (min 1); commit is driven from stage STAGES-1
MEM_STAGE, 0, stage index (0..STAGES-1) whose load also latches the mem_* sideband
XLEN, 32, data/PC/address width
ORDER_W, 64, rvfi_order width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
freeze  in  1  global stall (cache miss); every stage holds, no commit
hold0  in  1  forward stall; stage 0 holds, bubble enters stage 1
flush  in  1  branch kill; capture is discarded and stage 0 loads a bubble
cap_valid  in  1  capture point holds a real instruction
cap_inst  in  32  instruction word
cap_pc  in  XLEN  instruction PC
cap_next_pc  in  XLEN  resolved next PC (branch target or pc+4)
cap_rs1_rdata  in  XLEN  forwarded rs1 value
cap_rs2_rdata  in  XLEN  forwarded rs2 value
mem_addr  in  XLEN  dcache address of instruction entering MEM_STAGE
mem_rmask  in  4  read byte mask, already gated by the read control bit
mem_wmask  in  4  write byte mask
mem_rdata  in  XLEN  dcache read data
mem_wdata  in  XLEN  dcache write data
wb_load_regfile  in  1  regfile write enable of the committing instruction
wb_rd_wdata  in  XLEN  regfile write data of the committing instruction
rvfi_valid  out  1  commit strobe
rvfi_order  out  ORDER_W  order of the current commit
rvfi_inst  out  32  committed instruction
rvfi_trap  out  1  illegal encoding
rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  out  5 each  inst[19:15], inst[24:20], inst[11:7]
rvfi_rs1_rdata, rvfi_rs2_rdata  out  XLEN each  captured operands
rvfi_load_regfile  out  1  wb_load_regfile passed through
rvfi_rd_wdata  out  XLEN  0 when rd_addr==0, else wb_rd_wdata
rvfi_pc_rdata, rvfi_pc_wdata  out  XLEN each  cap_pc, cap_next_pc of the committing entry
rvfi_mem_addr/rmask/wmask/rdata/wdata  out  XLEN/4/4/XLEN/XLEN  latched sideband
rvfi_halt  out  1  sticky infinite-loop flag

Behaviour:
- Each stage holds: valid, inst, pc, next_pc, rs1/rs2 rdata, mem fields. All stage valid bits reset to 0 asynchronously. Payload reset value is 0.
- Stage update on posedge clk while rst=0:
  - freeze=1: all stages hold. Priority: freeze > flush > hold0.
  - freeze=0, flush=1: stage0.valid<=0. Stages 1..STAGES-1 shift normally; flush does not kill older entries.
  - freeze=0, hold0=1, flush=0: stage0 holds. Stage1 loads a bubble (valid=0). Stages >=2 shift.
  - freeze=0, otherwise: stage0 <= cap_* with valid=cap_valid. Stage i <= stage i-1.
  - STAGES=1: hold0 only holds stage0, and the commit in that cycle still occurs.
- mem_* fields are written only when MEM_STAGE loads from its predecessor (or from cap when MEM_STAGE=0). They travel with the entry afterwards. A bubble load clears rmask/wmask to 0.
- Commit is combinational from the last stage:
  - rvfi_valid = last.valid & ~freeze & ~rst.
  - All rvfi_* fields come from the last stage. wb_* is sampled live.
- Trap: rvfi_trap = last.valid & (inst[6:0]==0 | inst[1:0]!=2'b11). A trapping entry still commits.
- Order counter:
  - rvfi_order resets to 0.
  - It increments by 1 on every clock edge where rvfi_valid=1. rvfi_order shows the pre-increment value.
  - It wraps modulo 2^ORDER_W without saturation.
- Halt:
  - Sets on a commit with pc_wdata==pc_rdata and pc_rdata!=0.
  - It is registered, so it appears the cycle after that commit.
  - It stays set until rst. Later commits continue and the order counter still counts.
- All outputs other than the halt/order state are combinational. With reset asserted, every valid is 0, so rvfi_valid=0 and rvfi_halt=0.
- Reset mid-operation: all in-flight entries are dropped. There is no partial commit after reset deassertion.

Test Plan:
- STAGES=2, three back-to-back cap (pc 0x60, 0x64, 0x68; next_pc +4) -> commits on cycles 2, 3, 4 with order 0, 1, 2; pc_wdata 0x64/0x68/0x6C.
- Two-cycle freeze=1 mid-stream -> rvfi_valid low both cycles; the same entry commits once afterwards; order has no gap or duplicate.
- hold0=1 for 1 cycle with 0x64 in stage0 -> one idle commit cycle, then 0x64 commits once with the rs1/rs2 values captured originally.
- flush with cap 0x70 while 0x6C is in stage0 -> 0x6C commits, 0x70 never commits; next commit order is contiguous.
- Load at MEM_STAGE (addr 0x100, rmask 0xF, rdata 0xDEADBEEF) -> same values on rvfi_mem_* at its commit. A following ALU op shows rmask=wmask=0.
- Commit pc_rdata=pc_wdata=0x80 -> halt=1 the next cycle and stays set through later commits. rd=x0 with wb_rd_wdata=0x5 -> rvfi_rd_wdata=0. ORDER_W=4 with 17 commits -> order wraps 15→0.

Source files
------------

// File: rtl/rvfi_shadow_pipe.sv
// Purpose : RVFI shadow pipeline that carries retirement metadata from the resolve point to commit.
// Latency : STAGES cycles from capture to the rvfi_valid strobe; commit outputs are combinational from the last stage.
// Backpr. : no ready input; freeze stalls every stage, hold0 stalls stage 0 and inserts a bubble, flush drops the capture.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   freeze / hold0 / flush      core pipeline control (priority freeze > flush > hold0)
//   cap_*                       instruction metadata at the resolve point
//   mem_*                       dcache sideband for the entry loading into MEM_STAGE
//   wb_*                        live writeback info of the committing instruction
//   rvfi_*                      RVFI commit packet, order counter and sticky halt flag
module rvfi_shadow_pipe #(
    parameter int STAGES    = 2,
    parameter int MEM_STAGE = 0,
    parameter int XLEN      = 32,
    parameter int ORDER_W   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               hold0,
    input  logic               flush,
    input  logic               cap_valid,
    input  logic [31:0]        cap_inst,
    input  logic [XLEN-1:0]    cap_pc,
    input  logic [XLEN-1:0]    cap_next_pc,
    input  logic [XLEN-1:0]    cap_rs1_rdata,
    input  logic [XLEN-1:0]    cap_rs2_rdata,
    input  logic [XLEN-1:0]    mem_addr,
    input  logic [3:0]         mem_rmask,
    input  logic [3:0]         mem_wmask,
    input  logic [XLEN-1:0]    mem_rdata,
    input  logic [XLEN-1:0]    mem_wdata,
    input  logic               wb_load_regfile,
    input  logic [XLEN-1:0]    wb_rd_wdata,
    output logic               rvfi_valid,
    output logic [ORDER_W-1:0] rvfi_order,
    output logic [31:0]        rvfi_inst,
    output logic               rvfi_trap,
    output logic [4:0]         rvfi_rs1_addr,
    output logic [4:0]         rvfi_rs2_addr,
    output logic [4:0]         rvfi_rd_addr,
    output logic [XLEN-1:0]    rvfi_rs1_rdata,
    output logic [XLEN-1:0]    rvfi_rs2_rdata,
    output logic               rvfi_load_regfile,
    output logic [XLEN-1:0]    rvfi_rd_wdata,
    output logic [XLEN-1:0]    rvfi_pc_rdata,
    output logic [XLEN-1:0]    rvfi_pc_wdata,
    output logic [XLEN-1:0]    rvfi_mem_addr,
    output logic [3:0]         rvfi_mem_rmask,
    output logic [3:0]         rvfi_mem_wmask,
    output logic [XLEN-1:0]    rvfi_mem_rdata,
    output logic [XLEN-1:0]    rvfi_mem_wdata,
    output logic               rvfi_halt
);

    localparam int LAST = STAGES - 1;

    // One shadow entry; the whole record moves as a unit between stages.
    typedef struct packed {
        logic            valid;
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] next_pc;
        logic [XLEN-1:0] rs1_rdata;
        logic [XLEN-1:0] rs2_rdata;
        logic [XLEN-1:0] mem_addr;
        logic [3:0]      mem_rmask;
        logic [3:0]      mem_wmask;
        logic [XLEN-1:0] mem_rdata;
        logic [XLEN-1:0] mem_wdata;
    } entry_t;

    entry_t             stage_q [STAGES];
    entry_t             stage_d [STAGES];
    entry_t             cap_entry;
    entry_t             last;

    logic [ORDER_W-1:0] order_q;
    logic [ORDER_W-1:0] order_d;
    logic               halt_q;
    logic               halt_d;
    logic               commit;
    logic               halt_hit;

    // ------------------------------------------------------------------
    // Capture record. When stage 0 is the memory stage the sideband is
    // latched together with the capture; masks are gated by the capture's
    // valid so a bubble never carries a stale access.
    // ------------------------------------------------------------------
    always_comb begin
        cap_entry           = '0;
        cap_entry.valid     = cap_valid;
        cap_entry.inst      = cap_inst;
        cap_entry.pc        = cap_pc;
        cap_entry.next_pc   = cap_next_pc;
        cap_entry.rs1_rdata = cap_rs1_rdata;
        cap_entry.rs2_rdata = cap_rs2_rdata;
        if (MEM_STAGE == 0) begin
            cap_entry.mem_addr  = mem_addr;
            cap_entry.mem_rmask = cap_valid ? mem_rmask : 4'h0;
            cap_entry.mem_wmask = cap_valid ? mem_wmask : 4'h0;
            cap_entry.mem_rdata = mem_rdata;
            cap_entry.mem_wdata = mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Stage advance. Default is hold, which also covers freeze.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stage_d[i] = stage_q[i];
        end

        if (!freeze) begin
            // Stage 0: flush kills only the capture, hold0 keeps the
            // current occupant, otherwise take the capture.
            if (flush) begin
                stage_d[0].valid = 1'b0;
                if (MEM_STAGE == 0) begin
                    stage_d[0].mem_rmask = 4'h0;
                    stage_d[0].mem_wmask = 4'h0;
                end
            end else if (!hold0) begin
                stage_d[0] = cap_entry;
            end

            // Older stages always shift, except that a hold0 without a
            // flush feeds a bubble into stage 1 because stage 0 stays put.
            for (int i = 1; i < STAGES; i++) begin
                if (hold0 && !flush && (i == 1)) begin
                    stage_d[i].valid = 1'b0;
                    if (i == MEM_STAGE) begin
                        stage_d[i].mem_rmask = 4'h0;
                        stage_d[i].mem_wmask = 4'h0;
                    end
                end else begin
                    stage_d[i] = stage_q[i-1];
                    if (i == MEM_STAGE) begin
                        stage_d[i].mem_addr  = mem_addr;
                        stage_d[i].mem_rmask = stage_q[i-1].valid ? mem_rmask : 4'h0;
                        stage_d[i].mem_wmask = stage_q[i-1].valid ? mem_wmask : 4'h0;
                        stage_d[i].mem_rdata = mem_rdata;
                        stage_d[i].mem_wdata = mem_wdata;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit, order and halt.
    // ------------------------------------------------------------------
    assign last     = stage_q[LAST];
    assign commit   = last.valid & ~freeze & ~rst;

    // A committed self-jump (outside the null PC) marks the infinite loop
    // the core parks in when the program is done.
    assign halt_hit = commit & (last.next_pc == last.pc) & (last.pc != '0);

    always_comb begin
        order_d = order_q;
        halt_d  = halt_q;
        if (commit) begin
            order_d = order_q + {{(ORDER_W-1){1'b0}}, 1'b1};
        end
        if (halt_hit) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            order_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
            order_q <= order_d;
            halt_q  <= halt_d;
        end
    end

    // ------------------------------------------------------------------
    // RVFI packet
    // ------------------------------------------------------------------
    assign rvfi_valid        = commit;
    assign rvfi_order        = order_q;
    assign rvfi_inst         = last.inst;
    assign rvfi_trap         = last.valid & ((last.inst[6:0] == 7'd0) | (last.inst[1:0] != 2'b11));
    assign rvfi_rs1_addr     = last.inst[19:15];
    assign rvfi_rs2_addr     = last.inst[24:20];
    assign rvfi_rd_addr      = last.inst[11:7];
    assign rvfi_rs1_rdata    = last.rs1_rdata;
    assign rvfi_rs2_rdata    = last.rs2_rdata;
    assign rvfi_load_regfile = wb_load_regfile;
    // x0 is hard-wired zero regardless of what writeback drives.
    assign rvfi_rd_wdata     = (last.inst[11:7] == 5'd0) ? '0 : wb_rd_wdata;
    assign rvfi_pc_rdata     = last.pc;
    assign rvfi_pc_wdata     = last.next_pc;
    assign rvfi_mem_addr     = last.mem_addr;
    assign rvfi_mem_rmask    = last.mem_rmask;
    assign rvfi_mem_wmask    = last.mem_wmask;
    assign rvfi_mem_rdata    = last.mem_rdata;
    assign rvfi_mem_wdata    = last.mem_wdata;
    assign rvfi_halt         = halt_q;

endmodule

// File: tb/tb_rvfi_shadow_pipe.sv
// Purpose : scoreboard bench for rvfi_shadow_pipe (STAGES=2, MEM_STAGE=0, ORDER_W=4).
// Latency : expected commits are queued at capture and popped when rvfi_valid is seen.
// Backpr. : freeze/hold0/flush cycles are driven directly; none of them queue an entry.
module tb_rvfi_shadow_pipe;

    localparam logic [31:0] I_ADDI  = 32'h0051_0093; // addi x1,x2,5
    localparam logic [31:0] I_ADD   = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] I_LW    = 32'h0000_2283; // lw   x5,0(x0)
    localparam logic [31:0] I_SW    = 32'h0060_2223; // sw   x6,4(x0)
    localparam logic [31:0] I_ADDX0 = 32'h0050_0013; // addi x0,x0,5
    localparam logic [31:0] I_JAL0  = 32'h0000_006F; // jal  x0,0
    localparam logic [31:0] I_ZERO  = 32'h0000_0000; // illegal
    localparam logic [31:0] I_C01   = 32'h0000_0001; // not a 32-bit encoding

    logic        clk, rst, freeze, hold0, flush, cap_valid;
    logic [31:0] cap_inst, cap_pc, cap_next_pc, cap_rs1_rdata, cap_rs2_rdata;
    logic [31:0] mem_addr, mem_rdata, mem_wdata;
    logic [3:0]  mem_rmask, mem_wmask;
    logic        wb_load_regfile;
    logic [31:0] wb_rd_wdata;

    logic        rvfi_valid, rvfi_trap, rvfi_load_regfile, rvfi_halt;
    logic [3:0]  rvfi_order, rvfi_mem_rmask, rvfi_mem_wmask;
    logic [31:0] rvfi_inst, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;

    // Writeback model: follows the committing PC so each commit sees distinct live values.
    assign wb_rd_wdata     = rvfi_pc_rdata ^ 32'h0000_0005;
    assign wb_load_regfile = rvfi_pc_rdata[2];

    rvfi_shadow_pipe #(.STAGES(2), .MEM_STAGE(0), .XLEN(32), .ORDER_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .hold0(hold0), .flush(flush),
        .cap_valid(cap_valid), .cap_inst(cap_inst), .cap_pc(cap_pc), .cap_next_pc(cap_next_pc),
        .cap_rs1_rdata(cap_rs1_rdata), .cap_rs2_rdata(cap_rs2_rdata),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .wb_load_regfile(wb_load_regfile), .wb_rd_wdata(wb_rd_wdata),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_inst(rvfi_inst), .rvfi_trap(rvfi_trap),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_load_regfile(rvfi_load_regfile), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .rvfi_halt(rvfi_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst, pc, npc, rs1, rs2, maddr, mrd, mwd;
        logic [3:0]  rm, wm, order;
        logic        halt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [3:0]  exp_order = 4'd0;
    logic        halt_seen = 1'b0;
    logic        req_empty = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: the only process that compares.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_valid", {63'd0, rvfi_valid}, 64'd0);
                chk("rst_halt",  {63'd0, rvfi_halt},  64'd0);
                chk("rst_order", {60'd0, rvfi_order}, 64'd0);
            end else begin
                if (rvfi_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_commit: got commit pc 0x%0h, expected none", rvfi_pc_rdata);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("order",     {60'd0, rvfi_order},     {60'd0, e.order});
                        chk("inst",      {32'd0, rvfi_inst},      {32'd0, e.inst});
                        chk("pc_rdata",  {32'd0, rvfi_pc_rdata},  {32'd0, e.pc});
                        chk("pc_wdata",  {32'd0, rvfi_pc_wdata},  {32'd0, e.npc});
                        chk("rs1_rdata", {32'd0, rvfi_rs1_rdata}, {32'd0, e.rs1});
                        chk("rs2_rdata", {32'd0, rvfi_rs2_rdata}, {32'd0, e.rs2});
                        chk("rs1_addr",  {59'd0, rvfi_rs1_addr},  {59'd0, e.inst[19:15]});
                        chk("rs2_addr",  {59'd0, rvfi_rs2_addr},  {59'd0, e.inst[24:20]});
                        chk("rd_addr",   {59'd0, rvfi_rd_addr},   {59'd0, e.inst[11:7]});
                        chk("rd_wdata",  {32'd0, rvfi_rd_wdata},
                            {32'd0, (e.inst[11:7] == 5'd0) ? 32'd0 : (e.pc ^ 32'h5)});
                        chk("load_regfile", {63'd0, rvfi_load_regfile}, {63'd0, e.pc[2]});
                        chk("trap", {63'd0, rvfi_trap},
                            {63'd0, (e.inst[6:0] == 7'd0) || (e.inst[1:0] != 2'b11)});
                        chk("mem_addr",  {32'd0, rvfi_mem_addr},  {32'd0, e.maddr});
                        chk("mem_rmask", {60'd0, rvfi_mem_rmask}, {60'd0, e.rm});
                        chk("mem_wmask", {60'd0, rvfi_mem_wmask}, {60'd0, e.wm});
                        chk("mem_rdata", {32'd0, rvfi_mem_rdata}, {32'd0, e.mrd});
                        chk("mem_wdata", {32'd0, rvfi_mem_wdata}, {32'd0, e.mwd});
                        chk("halt",      {63'd0, rvfi_halt},      {63'd0, e.halt});
                    end
                end
                if (req_empty) begin
                    chk("drained_queue_size", 64'(exp_q.size()), 64'd0);
                end
            end
        end
    end

    // One cycle of stimulus; queues the expected commit when the capture is taken.
    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] npc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] maddr, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] mrd, input logic [31:0] mwd,
                         input logic fr, input logic h0, input logic fl, input bit track);
        exp_t e;
        cap_valid = v;  cap_inst = inst;  cap_pc = pc;  cap_next_pc = npc;
        cap_rs1_rdata = rs1;  cap_rs2_rdata = rs2;
        mem_addr = maddr;  mem_rmask = rm;  mem_wmask = wm;  mem_rdata = mrd;  mem_wdata = mwd;
        freeze = fr;  hold0 = h0;  flush = fl;
        if (v && !fr && !fl && !h0 && track) begin
            e.inst = inst;  e.pc = pc;  e.npc = npc;  e.rs1 = rs1;  e.rs2 = rs2;
            e.maddr = maddr;  e.rm = rm;  e.wm = wm;  e.mrd = mrd;  e.mwd = mwd;
            e.order = exp_order;
            e.halt  = halt_seen;
            exp_q.push_back(e);
            exp_order = exp_order + 4'd1;
            if (pc == npc && pc != 32'd0) halt_seen = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] npc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        drive(1'b1, inst, pc, npc, rs1, rs2, 32'd0, 4'h0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'h0, 4'h0, 32'd0, 32'd0,
                  1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_drained();
        idle(4);
        req_empty = 1'b1;
        @(posedge clk);
        #1;
        req_empty = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'h0, 4'h0, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // back-to-back stream
        issue(I_ADDI, 32'h60, 32'h64, 32'h11, 32'h12);
        issue(I_ADD,  32'h64, 32'h68, 32'h21, 32'h22);
        issue(I_ADDI, 32'h68, 32'h6C, 32'h31, 32'h32);
        // two-cycle freeze with a capture presented but not taken
        for (int k = 0; k < 2; k++)
            drive(1'b1, I_ADD, 32'h6C, 32'h70, 32'h41, 32'h42, 32'd0, 4'h0, 4'h0, 32'd0, 32'd0,
                  1'b1, 1'b0, 1'b0, 1'b1);
        issue(I_ADD,  32'h6C, 32'h70, 32'h41, 32'h42);
        // hold0: stage 0 keeps 0x74 with its original operands
        issue(I_ADDI, 32'h74, 32'h78, 32'h51, 32'h52);
        drive(1'b1, I_ADD, 32'h78, 32'h7C, 32'hBAD1, 32'hBAD2, 32'd0, 4'h0, 4'h0, 32'd0, 32'd0,
              1'b0, 1'b1, 1'b0, 1'b1);
        issue(I_ADD,  32'h78, 32'h7C, 32'h61, 32'h62);
        // flush kills the capture, not the older entry
        issue(I_ADDI, 32'h7C, 32'h84, 32'h71, 32'h72);
        drive(1'b1, I_ADD, 32'hA0, 32'hA4, 32'h81, 32'h82, 32'd0, 4'h0, 4'h0, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b1, 1'b1);
        // memory sideband: load, ALU op, store
        drive(1'b1, I_LW, 32'h84, 32'h88, 32'h0, 32'h0, 32'h100, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0,
              1'b0, 1'b0, 1'b0, 1'b1);
        issue(I_ADD,  32'h88, 32'h8C, 32'h91, 32'h92);
        drive(1'b1, I_SW, 32'h8C, 32'h90, 32'h0, 32'hCAFE, 32'h104, 4'h0, 4'h3, 32'h0, 32'hCAFE,
              1'b0, 1'b0, 1'b0, 1'b1);
        // null self-jump must not halt, then rd=x0 zeroing
        issue(I_JAL0, 32'h0,  32'h0,  32'h0,  32'h0);
        issue(I_ADDX0, 32'h90, 32'h80, 32'h0, 32'h0);
        // real self-jump sets halt; later commits still flow
        issue(I_JAL0, 32'h80, 32'h80, 32'h0,  32'h0);
        issue(I_ADD,  32'h94, 32'h98, 32'h1,  32'h2);
        issue(I_ZERO, 32'h98, 32'h9C, 32'h3,  32'h4);
        issue(I_C01,  32'h9C, 32'hA0, 32'h5,  32'h6);
        // enough further commits to wrap the 4-bit order counter
        for (int k = 0; k < 6; k++)
            issue(I_ADD, 32'h200 + 32'(4*k), 32'h204 + 32'(4*k), 32'(k), 32'(k + 1));
        check_drained();

        // reset with an entry in flight: it must never commit
        drive(1'b1, I_ADD, 32'hC0, 32'hC4, 32'h7, 32'h8, 32'd0, 4'h0, 4'h0, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        exp_order = 4'd0;
        halt_seen = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        issue(I_ADDI, 32'hD0, 32'hD4, 32'h9, 32'hA);
        check_drained();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
